// File: rtl/fill_level_csr.sv
// ---------------------------------------------------------------------------
// fill_level_csr
//   Tracks the occupancy of an external buffer from push/pop strobes and
//   exposes it through a small 4-word CSR block with registered read data.
//
//   Optional feature: define FILL_LEVEL_HWM_EN to build the high-water-mark
//   register behind CSR word 2. Without it, word 2 reads 0 and ignores writes.
//
// Parameters
//   DEPTH       maximum occupancy of the tracked buffer
//   FULL_LEVEL  reset value of the almost-full threshold
//
// Ports
//   clk            single rising-edge clock
//   rst            synchronous active-high reset
//   push / pop     one entry added / removed this cycle
//   csr_address    word select: 0 occupancy, 1 status, 2 high-water, 3 threshold
//   csr_read       read request, data returned one cycle later
//   csr_write      write request
//   csr_writedata  write data
//   csr_readdata   registered read data, held when csr_read is low
//   almost_full    registered (occupancy >= threshold)
// ---------------------------------------------------------------------------
module fill_level_csr #(
    parameter int DEPTH      = 512,
    parameter int FULL_LEVEL = 490
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [1:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        almost_full
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] r_occ;
    logic          r_ovf;
    logic          r_udf;
    logic [15:0]   r_threshold;
    logic          r_almost_full;
    logic [31:0]   r_readdata;

    logic [CW-1:0] w_occ_next;
    logic          w_ovf_evt;
    logic          w_udf_evt;
    logic          w_wr_status;
    logic          w_wr_hwm;
    logic          w_wr_thr;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_occ_ext;
    logic [31:0]   w_occ_next_ext;
    logic [31:0]   w_hwm_ext;

    // Upper write-data bits have no destination.
    logic          w_unused_wdata;
    assign w_unused_wdata = ^csr_writedata[31:16];

    assign w_wr_status = csr_write && (csr_address == 2'd1);
    assign w_wr_hwm    = csr_write && (csr_address == 2'd2);
    assign w_wr_thr    = csr_write && (csr_address == 2'd3);

    // Occupancy update; push+pop together leaves the count unchanged.
    always_comb begin
        w_occ_next = r_occ;
        w_ovf_evt  = 1'b0;
        w_udf_evt  = 1'b0;
        if (push && !pop) begin
            if (r_occ == DEPTH_C) w_ovf_evt  = 1'b1;
            else                  w_occ_next = r_occ + 1'b1;
        end else if (pop && !push) begin
            if (r_occ == '0)      w_udf_evt  = 1'b1;
            else                  w_occ_next = r_occ - 1'b1;
        end
    end

    assign w_occ_ext      = 32'(r_occ);
    assign w_occ_next_ext = 32'(w_occ_next);

`ifdef FILL_LEVEL_HWM_EN
    logic [CW-1:0] r_hwm;

    // A clear reloads the mark from the occupancy being committed this edge,
    // so the mark never falls below the live count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hwm <= '0;
        end else if (w_wr_hwm) begin
            r_hwm <= w_occ_next;
        end else if (w_occ_next > r_hwm) begin
            r_hwm <= w_occ_next;
        end
    end

    assign w_hwm_ext = 32'(r_hwm);
`else
    logic w_unused_hwm;
    assign w_unused_hwm = w_wr_hwm;
    assign w_hwm_ext    = 32'd0;
`endif

    // Read mux sees only pre-edge register values, so a same-cycle write
    // returns the old contents.
    always_comb begin
        w_rd_word = 32'd0;
        case (csr_address)
            2'd0: w_rd_word = w_occ_ext;
            2'd1: w_rd_word = {29'd0, r_udf, r_ovf, r_almost_full};
            2'd2: w_rd_word = w_hwm_ext;
            2'd3: w_rd_word = {16'd0, r_threshold};
            default: w_rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ         <= '0;
            r_ovf         <= 1'b0;
            r_udf         <= 1'b0;
            r_threshold   <= 16'(FULL_LEVEL);
            r_almost_full <= 1'b0;
            r_readdata    <= 32'd0;
        end else begin
            r_occ <= w_occ_next;
            // A new event in the same cycle as a clear keeps the bit set.
            r_ovf <= (r_ovf & ~(w_wr_status & csr_writedata[1])) | w_ovf_evt;
            r_udf <= (r_udf & ~(w_wr_status & csr_writedata[2])) | w_udf_evt;
            if (w_wr_thr) begin
                r_threshold <= csr_writedata[15:0];
            end
            // Compare against the next count so the flag lines up with it.
            r_almost_full <= (w_occ_next_ext >= {16'd0, r_threshold});
            if (csr_read) begin
                r_readdata <= w_rd_word;
            end
        end
    end

    assign csr_readdata = r_readdata;
    assign almost_full  = r_almost_full;

endmodule

// File: tb/tb_fill_level_csr.sv
// ---------------------------------------------------------------------------
// tb_fill_level_csr
//   Directed bench for fill_level_csr. Two instances share all inputs:
//   u_big uses the default parameters, u_small uses DEPTH=4, FULL_LEVEL=4
//   so saturation can be reached in a few cycles.
// ---------------------------------------------------------------------------
module tb_fill_level_csr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [1:0]  csr_address = 2'd0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = 32'd0;
    logic [31:0] big_readdata;
    logic        big_almost_full;
    logic [31:0] small_readdata;
    logic        small_almost_full;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fill_level_csr u_big (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (big_readdata),
        .almost_full   (big_almost_full)
    );

    fill_level_csr #(.DEPTH(4), .FULL_LEVEL(4)) u_small (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (small_readdata),
        .almost_full   (small_almost_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-22s got=%0d", tag, got);
        end else begin
            $display("FAIL %-22s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] addr, output logic [31:0] big_d, output logic [31:0] small_d);
        csr_read    = 1'b1;
        csr_address = addr;
        step();
        csr_read    = 1'b0;
        big_d       = big_readdata;
        small_d     = small_readdata;
    endtask

    task automatic csr_wr(input logic [1:0] addr, input logic [31:0] data);
        csr_write     = 1'b1;
        csr_address   = addr;
        csr_writedata = data;
        step();
        csr_write     = 1'b0;
    endtask

    task automatic pulse(input logic p_push, input logic p_pop, input int n);
        for (int i = 0; i < n; i++) begin
            push = p_push;
            pop  = p_pop;
            step();
        end
        push = 1'b0;
        pop  = 1'b0;
    endtask

    logic [31:0] rb, rs;
    logic [31:0] hwm_exp_a, hwm_exp_b;

    initial begin
        // Reset state
        do_reset();
        check("rst_readdata", big_readdata, 32'd0);
        check("rst_almost_full", {31'd0, big_almost_full}, 32'd0);
        csr_rd(2'd0, rb, rs);  check("rst_occ", rb, 32'd0);
        csr_rd(2'd1, rb, rs);  check("rst_status", rb, 32'd0);
        csr_rd(2'd2, rb, rs);  check("rst_hwm", rb, 32'd0);
        csr_rd(2'd3, rb, rs);  check("rst_threshold", rb, 32'd490);

        // Continuous read of word 0 while pushing: each value lags one cycle
        do_reset();
        csr_read    = 1'b1;
        csr_address = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            push = 1'b1;
            step();
            if (k >= 2) check($sformatf("stream_occ%0d", k - 1), big_readdata, 32'(k - 1));
            check($sformatf("stream_af%0d", k), {31'd0, big_almost_full}, 32'd0);
        end
        push = 1'b0;
        step();
        check("stream_occ5", big_readdata, 32'd5);
        csr_read = 1'b0;
        step();
        check("readdata_hold", big_readdata, 32'd5);

        // Writes to word 0 are ignored
        csr_wr(2'd0, 32'd55);
        csr_rd(2'd0, rb, rs);  check("wr_word0_ignored", rb, 32'd5);

        // Threshold 4: almost_full rises with occupancy 4, falls at 3
        do_reset();
        csr_wr(2'd3, 32'd4);
        for (int k = 1; k <= 4; k++) begin
            pulse(1'b1, 1'b0, 1);
            check($sformatf("af_push%0d", k), {31'd0, big_almost_full}, (k >= 4) ? 32'd1 : 32'd0);
        end
        pulse(1'b0, 1'b1, 1);
        check("af_pop_fall", {31'd0, big_almost_full}, 32'd0);
        csr_rd(2'd0, rb, rs);  check("af_occ3", rb, 32'd3);
        csr_rd(2'd1, rb, rs);  check("af_status", rb, 32'd0);

        // Overflow on the DEPTH=4 instance
        do_reset();
        pulse(1'b1, 1'b0, 5);
        csr_rd(2'd0, rb, rs);
        check("ovf_small_occ", rs, 32'd4);
        check("ovf_big_occ", rb, 32'd5);
        csr_rd(2'd1, rb, rs);  check("ovf_small_status", rs, 32'd3);
        csr_wr(2'd1, 32'd2);
        csr_rd(2'd1, rb, rs);  check("ovf_w1c_status", rs, 32'd1);

        // Underflow, W1C, event-beats-clear, push+pop hold
        do_reset();
        pulse(1'b0, 1'b1, 1);
        csr_rd(2'd0, rb, rs);  check("udf_occ", rb, 32'd0);
        csr_rd(2'd1, rb, rs);  check("udf_status", rb, 32'd4);
        csr_wr(2'd1, 32'd4);
        csr_rd(2'd1, rb, rs);  check("udf_cleared", rb, 32'd0);
        pop = 1'b1;
        csr_wr(2'd1, 32'd4);
        pop = 1'b0;
        csr_rd(2'd1, rb, rs);  check("udf_evt_wins", rb, 32'd4);
        pulse(1'b1, 1'b0, 2);
        pulse(1'b1, 1'b1, 1);
        csr_rd(2'd0, rb, rs);  check("pushpop_hold", rb, 32'd2);

        // Same-cycle read and write of threshold returns old value
        csr_read = 1'b1;
        csr_wr(2'd3, 32'd10);
        csr_read = 1'b0;
        check("rw_same_old", big_readdata, 32'd490);
        csr_rd(2'd3, rb, rs);  check("rw_same_new", rb, 32'd10);
        csr_wr(2'd3, 32'hFFFF_0007);
        csr_rd(2'd3, rb, rs);  check("thr_low16_only", rb, 32'd7);

        // High-water mark
`ifdef FILL_LEVEL_HWM_EN
        hwm_exp_a = 32'd7;
        hwm_exp_b = 32'd2;
`else
        hwm_exp_a = 32'd0;
        hwm_exp_b = 32'd0;
`endif
        do_reset();
        pulse(1'b1, 1'b0, 7);
        pulse(1'b0, 1'b1, 5);
        csr_rd(2'd0, rb, rs);  check("hwm_occ", rb, 32'd2);
        csr_rd(2'd2, rb, rs);  check("hwm_peak", rb, hwm_exp_a);
        csr_wr(2'd2, 32'd0);
        csr_rd(2'd2, rb, rs);  check("hwm_reload", rb, hwm_exp_b);

        // Reset overrides push and read in the same cycle
        do_reset();
        pulse(1'b1, 1'b0, 3);
        csr_wr(2'd3, 32'd2);
        csr_read    = 1'b1;
        csr_address = 2'd0;
        push        = 1'b1;
        rst         = 1'b1;
        step();
        rst      = 1'b0;
        push     = 1'b0;
        csr_read = 1'b0;
        check("midrst_readdata", big_readdata, 32'd0);
        check("midrst_af", {31'd0, big_almost_full}, 32'd0);
        csr_rd(2'd0, rb, rs);  check("midrst_occ", rb, 32'd0);
        csr_rd(2'd3, rb, rs);  check("midrst_threshold", rb, 32'd490);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=%0d expected=%0d", n_checks, 0);
        $fatal(1, "timeout");
    end

endmodule
